// File: rtl/scan_decoder.sv
// scan_decoder: active-low one-hot channel strobe generator.
//   Direct mode (iMode=0) decodes iData onto oData.
//   Auto-scan mode (iMode=1) steps a channel index every DIV enabled
//   cycles through 0..NUM_CH-1 and pulses oWrap on each wrap-around.
//   The block is enabled only while iEna == 2'b01.
// Ports:
//   iClk    - clock, all state on rising edge
//   iRst_n  - asynchronous active-low reset
//   iEna    - enable code (2'b01 = enabled)
//   iMode   - 0 direct decode, 1 auto-scan
//   iData   - channel select in direct mode
//   oData   - registered active-low one-hot strobe (2**SEL_W bits)
//   oSel    - registered index of the driven channel
//   oWrap   - registered one-cycle pulse on scan wrap-around
module scan_decoder #(
  parameter int SEL_W  = 3,
  parameter int NUM_CH = 8,
  parameter int DIV    = 4
) (
  input  logic                  iClk,
  input  logic                  iRst_n,
  input  logic [1:0]            iEna,
  input  logic                  iMode,
  input  logic [SEL_W-1:0]      iData,
  output logic [2**SEL_W-1:0]   oData,
  output logic [SEL_W-1:0]      oSel,
  output logic                  oWrap
);

  localparam int OUT_W = 2**SEL_W;
  localparam int PRE_W = (DIV > 1) ? $clog2(DIV) : 1;
  localparam logic [PRE_W-1:0] PRE_LAST = PRE_W'(DIV - 1);
  localparam logic [SEL_W-1:0] IDX_LAST = SEL_W'(NUM_CH - 1);
  localparam logic [SEL_W:0]   CH_COUNT = (SEL_W + 1)'(NUM_CH);

  // All ones except the selected bit, which is driven low.
  function automatic logic [OUT_W-1:0] strobeLow(input logic [SEL_W-1:0] idx);
    logic [OUT_W-1:0] v;
    v      = {OUT_W{1'b1}};
    v[idx] = 1'b0;
    return v;
  endfunction

  logic [PRE_W-1:0] presc_r, presc_s;
  logic [SEL_W-1:0] scanIdx_r, scanIdx_s;
  logic             mode_r;
  logic [OUT_W-1:0] data_s;
  logic [SEL_W-1:0] sel_s;
  logic             wrap_s;
  logic             enabled_s;
  logic             modeChg_s;

  assign enabled_s = (iEna == 2'b01);
  assign modeChg_s = (iMode != mode_r);

  // Next-state logic for prescaler, scan index and the output registers.
  always_comb begin
    presc_s   = presc_r;
    scanIdx_s = scanIdx_r;
    data_s    = {OUT_W{1'b1}};
    sel_s     = oSel;
    wrap_s    = 1'b0;

    // A mode change restarts the scan regardless of enable.
    if (modeChg_s) begin
      presc_s   = {PRE_W{1'b0}};
      scanIdx_s = {SEL_W{1'b0}};
    end else begin
      presc_s   = presc_r;
      scanIdx_s = scanIdx_r;
    end

    if (enabled_s) begin
      if (!iMode) begin
        presc_s = {PRE_W{1'b0}};
        sel_s   = iData;
        // Out-of-range selects leave every channel inactive.
        if ({1'b0, iData} < CH_COUNT) begin
          data_s = strobeLow(iData);
        end else begin
          data_s = {OUT_W{1'b1}};
        end
      end else if (modeChg_s) begin
        // Entering scan: show channel 0, no step and no wrap this edge.
        sel_s  = {SEL_W{1'b0}};
        data_s = strobeLow({SEL_W{1'b0}});
      end else begin
        if (presc_r == PRE_LAST) begin
          presc_s = {PRE_W{1'b0}};
          if (scanIdx_r == IDX_LAST) begin
            scanIdx_s = {SEL_W{1'b0}};
            wrap_s    = 1'b1;
          end else begin
            scanIdx_s = scanIdx_r + SEL_W'(1);
          end
        end else begin
          presc_s = presc_r + PRE_W'(1);
        end
        sel_s  = scanIdx_s;
        data_s = strobeLow(scanIdx_s);
      end
    end else begin
      // Disabled: strobes off, index and prescaler hold (unless cleared above).
      data_s = {OUT_W{1'b1}};
    end
  end

  // State and output registers with asynchronous reset.
  always_ff @(posedge iClk or negedge iRst_n) begin
    if (!iRst_n) begin
      presc_r   <= {PRE_W{1'b0}};
      scanIdx_r <= {SEL_W{1'b0}};
      mode_r    <= 1'b0;
      oData     <= {OUT_W{1'b1}};
      oSel      <= {SEL_W{1'b0}};
      oWrap     <= 1'b0;
    end else begin
      presc_r   <= presc_s;
      scanIdx_r <= scanIdx_s;
      mode_r    <= iMode;
      oData     <= data_s;
      oSel      <= sel_s;
      oWrap     <= wrap_s;
    end
  end

endmodule

// File: tb/tb_scan_decoder.sv
// Testbench for scan_decoder: three instances (8ch/DIV4, 6ch/DIV1,
// 1ch/DIV3) share stimulus; each is compared every cycle against a
// cycle-count based reference model, plus table vectors and hand
// sequences for pause, wrap timing, async reset and mode toggling.
module tb_scan_decoder;

  logic       clk = 1'b0;
  logic       rst_n;
  logic [1:0] ena;
  logic       mode;
  logic [2:0] data;
  logic [7:0] od [3];
  logic [2:0] os [3];
  logic       ow [3];

  int checks = 0;
  int errors = 0;

  always #5 clk = ~clk;

  scan_decoder #(.SEL_W(3), .NUM_CH(8), .DIV(4)) dutA (
    .iClk(clk), .iRst_n(rst_n), .iEna(ena), .iMode(mode), .iData(data),
    .oData(od[0]), .oSel(os[0]), .oWrap(ow[0]));
  scan_decoder #(.SEL_W(3), .NUM_CH(6), .DIV(1)) dutB (
    .iClk(clk), .iRst_n(rst_n), .iEna(ena), .iMode(mode), .iData(data),
    .oData(od[1]), .oSel(os[1]), .oWrap(ow[1]));
  scan_decoder #(.SEL_W(3), .NUM_CH(1), .DIV(3)) dutC (
    .iClk(clk), .iRst_n(rst_n), .iEna(ena), .iMode(mode), .iData(data),
    .oData(od[2]), .oSel(os[2]), .oWrap(ow[2]));

  // Reference model: scan position is the number of enabled scan cycles
  // since the last restart; index and wrap follow by division.
  typedef struct {
    int         cnt;
    int         sel;
    logic [7:0] data;
    logic       wrap;
    logic       modeR;
  } mdl_t;

  mdl_t m [3];
  int   nchT [3] = '{8, 6, 1};
  int   divT [3] = '{4, 1, 3};

  function automatic mdl_t mstep(mdl_t p, int nch, int dv, logic [1:0] e,
                                 logic md, logic [2:0] d);
    mdl_t n;
    bit   en;
    n      = p;
    en     = (e == 2'b01);
    n.wrap = 1'b0;
    n.modeR = md;
    if (md != p.modeR) n.cnt = 0;
    if (!en) begin
      n.data = 8'hFF;
    end else if (!md) begin
      n.sel  = int'(d);
      n.data = (int'(d) < nch) ? ~(8'd1 << d) : 8'hFF;
    end else if (md != p.modeR) begin
      n.sel  = 0;
      n.data = 8'hFE;
    end else begin
      n.cnt  = p.cnt + 1;
      n.sel  = (n.cnt / dv) % nch;
      n.wrap = ((n.cnt % (dv * nch)) == 0);
      n.data = ~(8'd1 << n.sel);
    end
    return n;
  endfunction

  task automatic resetModels();
    for (int i = 0; i < 3; i++) begin
      m[i].cnt = 0; m[i].sel = 0; m[i].data = 8'hFF;
      m[i].wrap = 1'b0; m[i].modeR = 1'b0;
    end
  endtask

  task automatic chk(string name, logic [31:0] act, logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %0h expected %0h at %0t", name, act, exp, $time);
    end
  endtask

  task automatic checkAll();
    for (int i = 0; i < 3; i++) begin
      chk($sformatf("model oData[%0d]", i), 32'(od[i]), 32'(m[i].data));
      chk($sformatf("model oSel[%0d]", i), 32'(os[i]), 32'(m[i].sel));
      chk($sformatf("model oWrap[%0d]", i), 32'(ow[i]), 32'(m[i].wrap));
    end
  endtask

  // One clock: advance model with the inputs seen at the edge, sample 1 later.
  task automatic tick();
    @(posedge clk);
    if (rst_n) begin
      for (int i = 0; i < 3; i++) m[i] = mstep(m[i], nchT[i], divT[i], ena, mode, data);
    end
    #1;
    checkAll();
  endtask

  // Pulse reset between clock edges (called at posedge+1).
  task automatic doReset();
    #2 rst_n = 1'b0;
    #1 resetModels();
    checkAll();
    #4 rst_n = 1'b1;
  endtask

  typedef struct {
    logic [1:0] ena;
    logic [2:0] data;
    logic [7:0] expA;
    logic [2:0] expSel;
    logic [7:0] expB;
  } vec_t;

  vec_t vt [13];
  int   wrapEdges [$];
  int   sel4, sel5;
  int   r;

  initial begin
    vt[0]  = '{2'b01, 3'd0, 8'hFE, 3'd0, 8'hFE};
    vt[1]  = '{2'b01, 3'd1, 8'hFD, 3'd1, 8'hFD};
    vt[2]  = '{2'b01, 3'd2, 8'hFB, 3'd2, 8'hFB};
    vt[3]  = '{2'b01, 3'd3, 8'hF7, 3'd3, 8'hF7};
    vt[4]  = '{2'b01, 3'd4, 8'hEF, 3'd4, 8'hEF};
    vt[5]  = '{2'b01, 3'd5, 8'hDF, 3'd5, 8'hDF};
    vt[6]  = '{2'b01, 3'd6, 8'hBF, 3'd6, 8'hFF};
    vt[7]  = '{2'b01, 3'd7, 8'h7F, 3'd7, 8'hFF};
    vt[8]  = '{2'b00, 3'd3, 8'hFF, 3'd7, 8'hFF};
    vt[9]  = '{2'b10, 3'd3, 8'hFF, 3'd7, 8'hFF};
    vt[10] = '{2'b11, 3'd3, 8'hFF, 3'd7, 8'hFF};
    vt[11] = '{2'b01, 3'd3, 8'hF7, 3'd3, 8'hF7};
    vt[12] = '{2'b01, 3'd6, 8'hBF, 3'd6, 8'hFF};

    rst_n = 1'b0; ena = 2'b00; mode = 1'b0; data = 3'd0;
    resetModels();
    #12;
    chk("reset oData", 32'(od[0]), 32'hFF);
    chk("reset oSel", 32'(os[0]), 32'h0);
    chk("reset oWrap", 32'(ow[0]), 32'h0);
    rst_n = 1'b1;
    #2;
    chk("release no change", 32'(od[0]), 32'hFF);

    // Direct sweep and enable codes.
    for (int i = 0; i < 13; i++) begin
      ena = vt[i].ena; data = vt[i].data;
      tick();
      chk($sformatf("vec%0d oData", i), 32'(od[0]), 32'(vt[i].expA));
      chk($sformatf("vec%0d oSel", i), 32'(os[0]), 32'(vt[i].expSel));
      chk($sformatf("vec%0d oWrap", i), 32'(ow[0]), 32'h0);
      chk($sformatf("vec%0d oData6ch", i), 32'(od[1]), 32'(vt[i].expB));
    end

    // Scan from reset: wraps at edges 33 and 65.
    doReset();
    mode = 1'b1; ena = 2'b01;
    for (int e = 1; e <= 70; e++) begin
      tick();
      if (ow[0]) wrapEdges.push_back(e);
      if (e == 4) sel4 = int'(os[0]);
      if (e == 5) sel5 = int'(os[0]);
    end
    chk("scan sel edge4", 32'(sel4), 32'd0);
    chk("scan sel edge5", 32'(sel5), 32'd1);
    chk("wrap count", 32'(wrapEdges.size()), 32'd2);
    if (wrapEdges.size() == 2) begin
      chk("first wrap edge", 32'(wrapEdges[0]), 32'd33);
      chk("wrap period", 32'(wrapEdges[1] - wrapEdges[0]), 32'd32);
    end

    // Pause at oSel=5 with prescaler 2.
    doReset();
    for (int e = 1; e <= 23; e++) tick();
    chk("pause start sel", 32'(os[0]), 32'd5);
    ena = 2'b00;
    for (int e = 0; e < 10; e++) begin
      tick();
      chk("pause oData", 32'(od[0]), 32'hFF);
      chk("pause oSel", 32'(os[0]), 32'd5);
    end
    ena = 2'b01;
    tick();
    chk("resume oSel", 32'(os[0]), 32'd5);
    chk("resume oData", 32'(od[0]), 32'hDF);
    tick();
    chk("resume step", 32'(os[0]), 32'd6);

    // Async reset mid-cycle at oSel=4, then mode toggle restarts scan.
    doReset();
    for (int e = 1; e <= 18; e++) tick();
    chk("pre-reset sel", 32'(os[0]), 32'd4);
    #3 rst_n = 1'b0;
    #1;
    chk("async oData", 32'(od[0]), 32'hFF);
    chk("async oSel", 32'(os[0]), 32'd0);
    resetModels();
    #2 rst_n = 1'b1;
    for (int e = 1; e <= 10; e++) tick();
    chk("rescan sel", 32'(os[0]), 32'd2);
    mode = 1'b0; tick();
    mode = 1'b1; tick();
    chk("toggle sel", 32'(os[0]), 32'd0);
    for (int e = 0; e < 3; e++) tick();
    chk("toggle hold", 32'(os[0]), 32'd0);
    tick();
    chk("toggle step", 32'(os[0]), 32'd1);

    // Randomized stimulus against the model.
    for (int n = 0; n < 1500; n++) begin
      r = int'($urandom_range(0, 9));
      ena = (r < 7) ? 2'b01 : 2'($urandom_range(0, 3));
      if ($urandom_range(0, 39) == 0) mode = ~mode;
      data = 3'($urandom_range(0, 7));
      if ($urandom_range(0, 299) == 0) doReset();
      tick();
    end

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
